// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter: mode encodings and load clamping.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11   // reserved encoding, behaves as wrap
  } mode_e;

  // Clamp a load value into the legal count range 0..mod-1.
  function automatic int unsigned clamp_load(input int unsigned data, input int unsigned mod);
    return (data < mod) ? data : mod - 1;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles, cleared by clr.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Next prescaler value and tick; clr wins so no tick is issued in a load cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pre_d = pre_q;
    tick  = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Prescaler register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/counter_mod.sv
// Parametrised up/down counter with wrap, saturate and one-shot modes,
// optional prescaler, terminal-count strobe and sticky overflow flag.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MOD      = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             armed_q;

  logic             run_en, run_load, pre_tick, step;
  logic             is_oneshot, at_term, ovf_set;
  logic [WIDTH-1:0] term, load_val;
  mode_e            mode_s;

  // The first edge after reset release is idle: nothing loads, steps or ticks.
  assign run_en   = en & armed_q;
  assign run_load = load & armed_q;

  generate
    if (PRESCALE > 1) begin : g_prescale
      counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (run_load),
        .tick (pre_tick)
      );
    end else begin : g_no_prescale
      assign pre_tick = run_en & ~run_load;
    end
  endgenerate

  assign mode_s     = mode_e'(mode);
  assign is_oneshot = (mode_s == MODE_ONESHOT);
  // A completed one-shot swallows steps until reload or mode change.
  assign step       = pre_tick & ~(is_oneshot & done_q);
  assign term       = up ? MOD_M1 : '0;
  assign at_term    = (cnt_q == term);
  assign tc         = step & at_term;
  assign load_val   = WIDTH'(clamp_load(32'(data), 32'(MOD)));

  // Next-state logic: load beats step; terminal behaviour depends on mode.
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_set = 1'b0;
    if (run_load) begin
      cnt_d  = load_val;
      done_d = 1'b0;
    end else begin
      if (!is_oneshot) done_d = 1'b0;
      if (step) begin
        if (!at_term) begin
          cnt_d = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        end else begin
          case (mode_s)
            MODE_SAT:     ovf_set = 1'b1;
            MODE_ONESHOT: done_d  = 1'b1;
            default: begin
              cnt_d   = up ? '0 : MOD_M1;
              ovf_set = 1'b1;
            end
          endcase
        end
      end
    end
    // Setting the flag wins over a simultaneous clear request.
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model,
// on two instances (PRESCALE=1 and PRESCALE=4) sharing the same inputs.
module tb_counter_mod;

  localparam int W = 5;
  localparam int M = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, load = 1'b0, up = 1'b1, clr_ovf = 1'b0;
  logic [W-1:0] data = '0;
  logic [1:0]   mode = 2'b00;

  logic [W-1:0] cnt1, cnt4;
  logic         tc1, tc4, ovf1, ovf4, done1, done4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_mod #(.WIDTH(W), .MOD(M), .PRESCALE(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up),
    .mode(mode), .clr_ovf(clr_ovf), .cnt(cnt1), .tc(tc1), .ovf(ovf1), .done(done1));

  counter_mod #(.WIDTH(W), .MOD(M), .PRESCALE(4)) d4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up),
    .mode(mode), .clr_ovf(clr_ovf), .cnt(cnt4), .tc(tc4), .ovf(ovf4), .done(done4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int cnt;
    int pre;   // enabled cycles seen in the current prescale period
    bit ovf;
    bit done;
    bit armed; // false only for the idle edge after reset
  } mstate_t;

  localparam mstate_t M_RESET = '{cnt: 0, pre: 0, ovf: 1'b0, done: 1'b0, armed: 1'b0};

  function automatic bit m_step(mstate_t s, int ps);
    return s.armed && en && !load && (s.pre == ps - 1) && !(mode == 2'b10 && s.done);
  endfunction

  function automatic bit m_tc(mstate_t s, int ps);
    int term = up ? M - 1 : 0;
    return m_step(s, ps) && (s.cnt == term);
  endfunction

  function automatic mstate_t m_next(mstate_t s, int ps);
    mstate_t n = s;
    bit set_ovf = 1'b0;
    int term = up ? M - 1 : 0;
    if (!s.armed) begin
      n.armed = 1'b1;
      return n;
    end
    if (load) begin
      n.cnt  = (int'(data) < M) ? int'(data) : M - 1;
      n.pre  = 0;
      n.done = 1'b0;
    end else begin
      if (en) n.pre = (s.pre + 1) % ps;
      if (mode != 2'b10) n.done = 1'b0;
      if (m_step(s, ps)) begin
        if (s.cnt != term) n.cnt = up ? s.cnt + 1 : s.cnt - 1;
        else if (mode == 2'b01) set_ovf = 1'b1;
        else if (mode == 2'b10) n.done = 1'b1;
        else begin
          n.cnt = up ? 0 : M - 1;
          set_ovf = 1'b1;
        end
      end
    end
    if (set_ovf) n.ovf = 1'b1;
    else if (clr_ovf) n.ovf = 1'b0;
    return n;
  endfunction

  mstate_t m1, m4;

  // Advance both models on each clock edge, or reset them asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= M_RESET;
      m4 <= M_RESET;
    end else begin
      m1 <= m_next(m1, 1);
      m4 <= m_next(m4, 4);
    end
  end

  // Compare every output of both instances against the model on the falling edge.
  always @(negedge clk) begin
    check("d1.cnt",  32'(cnt1),  m1.cnt);
    check("d1.ovf",  32'(ovf1),  32'(m1.ovf));
    check("d1.done", 32'(done1), 32'(m1.done));
    check("d1.tc",   32'(tc1),   32'(m_tc(m1, 1)));
    check("d4.cnt",  32'(cnt4),  m4.cnt);
    check("d4.ovf",  32'(ovf4),  32'(m4.ovf));
    check("d4.done", 32'(done4), 32'(m4.done));
    check("d4.tc",   32'(tc4),   32'(m_tc(m4, 4)));
  end

  // Advance to just after the next rising edge; inputs change only here.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios + random ----------------
  initial begin
    int tc_n;
    int sat_cnt[5]  = '{1, 0, 0, 0, 0};
    int sat_tc[5]   = '{0, 0, 1, 1, 1};
    int sat_clr[5]  = '{0, 0, 0, 1, 0};
    int sat_ovf[5]  = '{0, 0, 1, 1, 1};
    int os_cnt[5]   = '{22, 23, 23, 23, 23};
    int os_tc[5]    = '{0, 0, 1, 0, 0};
    int os_done[5]  = '{0, 0, 1, 1, 1};
    bit gap_en[6]   = '{1, 1, 0, 0, 1, 1};
    int gap_cnt[6]  = '{3, 3, 3, 3, 3, 4};

    repeat (2) cycle();
    rst = 1'b0;
    cycle();                       // idle edge after release
    en = 1'b1;
    repeat (7) cycle();
    check("pre_reset_cnt", 32'(cnt1), 7);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt",  32'(cnt1),  0);
    check("async_rst_ovf",  32'(ovf1),  0);
    check("async_rst_done", 32'(done1), 0);
    en  = 1'b0;
    rst = 1'b0;
    cycle();                       // idle edge
    en = 1'b1;
    tc_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (tc1) tc_n++;
      cycle();
    end
    check("wrap30_cnt", 32'(cnt1), 6);
    check("wrap30_tc_pulses", tc_n, 1);
    check("wrap30_ovf", 32'(ovf1), 1);

    // Load clamp and priority over step.
    data = 5'd10; load = 1'b1;
    cycle();
    check("load10_no_step", 32'(cnt1), 10);
    data = 5'd30;
    cycle();
    check("load30_clamp", 32'(cnt1), 23);

    // Saturate down.
    mode = 2'b01; up = 1'b0; data = 5'd2; clr_ovf = 1'b1;
    cycle();
    load = 1'b0; clr_ovf = 1'b0;
    check("sat_load_ovf_clr", 32'(ovf1), 0);
    for (int i = 0; i < 5; i++) begin
      clr_ovf = sat_clr[i][0];
      #1;
      check($sformatf("sat_tc%0d", i), 32'(tc1), sat_tc[i]);
      cycle();
      check($sformatf("sat_cnt%0d", i), 32'(cnt1), sat_cnt[i]);
      check($sformatf("sat_ovf%0d", i), 32'(ovf1), sat_ovf[i]);
    end
    en = 1'b0; clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("sat_clr_later", 32'(ovf1), 0);

    // One-shot up.
    mode = 2'b10; up = 1'b1; data = 5'd21; load = 1'b1; en = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("os_tc%0d", i), 32'(tc1), os_tc[i]);
      cycle();
      check($sformatf("os_cnt%0d", i), 32'(cnt1), os_cnt[i]);
      check($sformatf("os_done%0d", i), 32'(done1), os_done[i]);
    end
    check("os_ovf_unaffected", 32'(ovf1), 0);
    data = 5'd0; load = 1'b1;
    cycle();
    load = 1'b0;
    check("os_reload_done", 32'(done1), 0);
    cycle();
    check("os_resume", 32'(cnt1), 1);

    // Prescaler on the PRESCALE=4 instance.
    mode = 2'b00; data = 5'd0; load = 1'b1; en = 1'b0;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check($sformatf("pre_cnt_k%0d", k), 32'(cnt4), k / 4);
    end
    for (int i = 0; i < 6; i++) begin
      en = gap_en[i];
      cycle();
      check($sformatf("pre_gap%0d", i), 32'(cnt4), gap_cnt[i]);
    end

    // Direction change and down-wrap at zero.
    data = 5'd4; load = 1'b1; en = 1'b0; up = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1;
    cycle();
    check("dir_up5", 32'(cnt1), 5);
    up = 1'b0;
    cycle();
    check("dir_down4", 32'(cnt1), 4);
    data = 5'd0; load = 1'b1; en = 1'b0; clr_ovf = 1'b1;
    cycle();
    load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
    #1;
    check("downwrap_tc", 32'(tc1), 1);
    cycle();
    check("downwrap_cnt", 32'(cnt1), 23);
    check("downwrap_ovf", 32'(ovf1), 1);

    // Random stimulus; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 19) == 0);
      data    = W'($urandom);
      clr_ovf = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
